// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory read port, the decode
// handshake, and the redirect/control lines.
// master = the fetch unit, slave = memory/decode/branch environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic              ifu_valid;
    logic [7:0]        ifu_instr;
    logic [ADDR_W-1:0] ifu_pc;
    logic              id_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halted;

    modport master (
        input  fetch_en,
        input  imem_data,
        input  id_ready,
        input  redirect_valid,
        input  redirect_addr,
        output imem_addr,
        output ifu_valid,
        output ifu_instr,
        output ifu_pc,
        output halted
    );

    modport slave (
        output fetch_en,
        output imem_data,
        output id_ready,
        output redirect_valid,
        output redirect_addr,
        input  imem_addr,
        input  ifu_valid,
        input  ifu_instr,
        input  ifu_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the 8-bit instruction memory
// combinationally, buffers {pc, instr} pairs in a small prefetch FIFO and
// presents the head to decode over valid/ready. Redirects flush the FIFO
// and restart fetch; the unit halts after the last program byte drains.
// Optional macro IFU_PERF_CNT_EN adds a 16-bit saturating stall counter.
module instr_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int PROG_LEN   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    instr_fetch_unit_if.master  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    // Program bounds carried one bit wider so PROG_LEN == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0]   PROG_END  = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(PROG_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Prefetch storage; contents are only observed through the valid mask,
    // so it needs no reset.
    logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [7:0]        fifo_instr_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic pc_in_range;
    logic redirect_take;
    logic redirect_in_range;
    logic fetch_allowed;
    logic do_pop;
    logic do_push;

    assign fifo_empty        = (count_q == '0);
    assign fifo_full         = (count_q == DEPTH_CNT);
    assign pc_in_range       = ({1'b0, pc_q} < PROG_END);
    assign redirect_in_range = ({1'b0, bus.redirect_addr} < PROG_END);

    // Read port and decode-side outputs: head entry, zeroed when empty.
    assign bus.imem_addr = pc_q;
    assign bus.ifu_valid = !fifo_empty;
    assign bus.ifu_pc    = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
    assign bus.ifu_instr = fifo_empty ? '0 : fifo_instr_q[rd_ptr_q];
    assign bus.halted    = (state_q == ST_HALT);

    // Handshake qualification: a redirect outranks both push and pop, and is
    // ignored until fetch has been started.
    always_comb begin
        redirect_take = bus.redirect_valid && (state_q != ST_IDLE);
        do_pop        = !fifo_empty && bus.id_ready && !redirect_take;
        fetch_allowed = (state_q == ST_RUN) && bus.fetch_en && !redirect_take && pc_in_range;
        do_push       = fetch_allowed && (!fifo_full || do_pop);
    end

    // Fetch control FSM: IDLE -> RUN -> DRAIN -> HALT, redirects re-enter RUN or DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fetch_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (do_push && (pc_q == LAST_PC)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (redirect_take) begin
            state_d = redirect_in_range ? ST_RUN : ST_DRAIN;
        end
    end

    // Program counter: advances on each push, reloads on redirect.
    always_comb begin
        pc_d = pc_q;
        if (redirect_take) begin
            pc_d = bus.redirect_addr;
        end else if (do_push) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // FIFO pointers and occupancy; a flush returns everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_take) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture the fetched byte together with the address it came from.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_data;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_event;

    // A stall is a cycle that wanted to fetch but found the FIFO full and undrained.
    always_comb begin
        stall_event = fetch_allowed && fifo_full && !do_pop;
        stall_cnt_d = stall_cnt_q;
        if (redirect_take) begin
            stall_cnt_d = '0;
        end else if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int ADDR_W   = 8;
    localparam int PROG_LEN = 5;
    localparam int DEPTH    = 2;

    typedef struct {
        int pc;
        int instr;
    } ent_t;

    logic clk;
    logic rst_n;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .PROG_LEN  (PROG_LEN),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef IFU_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .bus      (bus)
    );

    logic [7:0] tb_mem [256];
    int prog [5] = '{32'h49, 32'hC1, 32'h18, 32'hA9, 32'h4D};

    assign bus.imem_data = tb_mem[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit   m_started;
    int   m_pc;
    bit   m_done;
    bit   m_halt;
    int   m_stall;
    ent_t m_q[$];
    ent_t acc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_pc      = 0;
        m_done    = 0;
        m_halt    = 0;
        m_stall   = 0;
        m_q.delete();
    endtask

    // Apply one clock edge worth of rules to the model using current inputs.
    task automatic model_edge();
        bit   pop, full, want, push, halt_now;
        ent_t e;
        if (!m_started) begin
            if (bus.fetch_en) m_started = 1;
            return;
        end
        if (bus.redirect_valid) begin
            m_q.delete();
            m_pc    = int'(bus.redirect_addr);
            m_done  = (m_pc >= PROG_LEN);
            m_halt  = 0;
            m_stall = 0;
            return;
        end
        pop      = (m_q.size() > 0) && bus.id_ready;
        full     = (m_q.size() == DEPTH);
        want     = !m_done && bus.fetch_en;
        push     = want && (!full || pop);
        halt_now = m_done && (m_q.size() == 0);
        if (want && full && !pop && m_stall < 65535) m_stall++;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            e.pc    = m_pc;
            e.instr = int'(tb_mem[m_pc]);
            m_q.push_back(e);
            m_pc++;
            if (m_pc == PROG_LEN) m_done = 1;
        end
        if (halt_now) m_halt = 1;
    endtask

    task automatic model_check();
        chk("valid", 32'(bus.ifu_valid), 32'(m_q.size() > 0));
        chk("head_pc", 32'(bus.ifu_pc), (m_q.size() > 0) ? m_q[0].pc : 0);
        chk("head_instr", 32'(bus.ifu_instr), (m_q.size() > 0) ? m_q[0].instr : 0);
        chk("imem_addr", 32'(bus.imem_addr), m_pc);
        chk("halted", 32'(bus.halted), 32'(m_halt));
`ifdef IFU_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
    endtask

    // One clock: record any handshake that completes, clock, update model, check.
    task automatic cycle();
        ent_t e;
        if (bus.ifu_valid && bus.id_ready && !bus.redirect_valid) begin
            e.pc    = int'(bus.ifu_pc);
            e.instr = int'(bus.ifu_instr);
            acc.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
        model_check();
        $display("cyc t=%0t fen=%0b rdy=%0b redir=%0b/%0d valid=%0b pc=%0d instr=%02h addr=%0d halted=%0b",
                 $time, bus.fetch_en, bus.id_ready, bus.redirect_valid, bus.redirect_addr,
                 bus.ifu_valid, bus.ifu_pc, bus.ifu_instr, bus.imem_addr, bus.halted);
    endtask

    task automatic do_reset();
        bus.fetch_en       = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", 32'(bus.ifu_valid), 0);
        chk("rst_instr", 32'(bus.ifu_instr), 0);
        chk("rst_pc", 32'(bus.ifu_pc), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        rst_n = 1'b1;
        acc.delete();
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!bus.halted && n < budget) begin
            cycle();
            n++;
        end
        chk("halt_wait", 32'(bus.halted), 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) tb_mem[i] = 8'(prog[i]);
        rst_n = 1'b0;

        // Straight-line program, decode always ready
        do_reset();
        bus.fetch_en = 1'b1;
        bus.id_ready = 1'b1;
        cycle();
        chk("lat_edge1_valid", 32'(bus.ifu_valid), 0);
        cycle();
        chk("lat_edge2_valid", 32'(bus.ifu_valid), 1);
        chk("seq_pc0", 32'(bus.ifu_pc), 0);
        chk("seq_instr0", 32'(bus.ifu_instr), 32'h49);
        for (int i = 1; i < 5; i++) begin
            cycle();
            chk("seq_pc", 32'(bus.ifu_pc), i);
            chk("seq_instr", 32'(bus.ifu_instr), prog[i]);
        end
        cycle();
        chk("halt_not_yet", 32'(bus.halted), 0);
        cycle();
        chk("halt_after_last_pop", 32'(bus.halted), 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("halt_sticky", 32'(bus.halted), 1);
        end

        // Back-pressure: decode stalls six cycles
        do_reset();
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_addr_held", 32'(bus.imem_addr), 2);
        chk("bp_head_pc", 32'(bus.ifu_pc), 0);
        bus.id_ready = 1'b1;
        wait_halt(20);
        chk("bp_count", 32'(acc.size()), 5);
        for (int i = 0; i < 5 && i < acc.size(); i++) begin
            chk("bp_order_pc", 32'(acc[i].pc), i);
            chk("bp_order_instr", 32'(acc[i].instr), prog[i]);
        end

        // In-range redirect while head is pc=1
        do_reset();
        bus.fetch_en = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("rd_head_pc1", 32'(bus.ifu_pc), 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd3;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(bus.ifu_valid), 0);
        cycle();
        chk("rd_pc3", 32'(bus.ifu_pc), 3);
        chk("rd_instr3", 32'(bus.ifu_instr), 32'hA9);
        cycle();
        chk("rd_pc4", 32'(bus.ifu_pc), 4);
        chk("rd_instr4", 32'(bus.ifu_instr), 32'h4D);
        wait_halt(10);
        n = 0;
        foreach (acc[i]) if (acc[i].pc == 1) n++;
        chk("rd_pc1_never_taken", 32'(n), 0);
        chk("rd_acc_count", 32'(acc.size()), 3);

        // Out-of-range redirect, then restart from 0
        do_reset();
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd7;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("oor_flush_valid", 32'(bus.ifu_valid), 0);
        chk("oor_halted_early", 32'(bus.halted), 0);
        cycle();
        chk("oor_halted", 32'(bus.halted), 1);
        chk("oor_no_push", 32'(bus.ifu_valid), 0);
        cycle();
        chk("oor_addr_hold", 32'(bus.imem_addr), 7);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd0;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        chk("oor_restart_halt_drop", 32'(bus.halted), 0);
        cycle();
        chk("oor_restart_pc", 32'(bus.ifu_pc), 0);
        chk("oor_restart_instr", 32'(bus.ifu_instr), 32'h49);

        // Asynchronous reset with two entries buffered
        do_reset();
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("ar_full_valid", 32'(bus.ifu_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.ifu_valid), 0);
        chk("ar_addr", 32'(bus.imem_addr), 0);
        chk("ar_halted", 32'(bus.halted), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle();
        chk("ar_idle_first_edge", 32'(bus.ifu_valid), 0);
        cycle();
        chk("ar_idle_second_edge", 32'(bus.ifu_valid), 1);

`ifdef IFU_PERF_CNT_EN
        // Stall counter: ten full-and-blocked cycles, then cleared by redirect
        do_reset();
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 10; i++) cycle();
        chk("perf_stall10", 32'(stall_cnt), 10);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'd0;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("perf_clear", 32'(stall_cnt), 0);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.fetch_en       = ($urandom_range(0, 7) != 0);
            bus.id_ready       = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            bus.redirect_addr  = 8'($urandom_range(0, 8));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader side of the 8-bit instruction memory. Owns the program counter and drives the memory's read address.
- Samples the instruction byte returned combinationally in the same cycle and buffers {pc, instruction} pairs in a small prefetch FIFO.
- Hands the pairs to the decode stage over a valid/ready handshake.
- Supports branch/jump redirect with FIFO flush, and halts once the program end is reached.

Parameters:
- ADDR_W, 8, width of the PC and the instruction memory address.
- PROG_LEN, 5, number of valid program bytes; addresses at or above PROG_LEN are never fetched.
- FIFO_DEPTH, 2, number of prefetch buffer entries (power of two, 2 or 4).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  start/continue fetching; low pauses pushes.
- imem_addr  out  ADDR_W  read address to instruction memory; combinationally equal to pc.
- imem_data  in  8  instruction byte returned combinationally for imem_addr.
- ifu_valid  out  1  FIFO head holds a valid entry.
- ifu_instr  out  8  head instruction; [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd.
- ifu_pc  out  ADDR_W  address the head instruction was fetched from.
- id_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_addr  in  ADDR_W  new PC on redirect.
- halted  out  1  fetch finished and FIFO empty.

Behaviour:
- Reset (async assert, sync release): pc=0, FIFO empty, state=IDLE, ifu_valid=0, ifu_instr=0, ifu_pc=0, halted=0.
- States:
  - IDLE: no pushes. fetch_en=1 -> RUN at the next edge; no push on that edge.
  - RUN: a push occurs at an edge when fetch_en=1, no redirect, and (count<FIFO_DEPTH or a pop happens the same edge). A push writes {pc, imem_data} and sets pc<=pc+1. After the push from pc==PROG_LEN-1 -> DRAIN.
  - DRAIN: no pushes; when the FIFO is empty -> HALT.
  - HALT: halted=1; pc holds.
- Pop: occurs at an edge when ifu_valid && id_ready. Push and pop on the same edge keep count unchanged, including when full.
- Latency: first ifu_valid=1 two edges after fetch_en is first sampled high in IDLE. After that, one push per cycle while not back-pressured.
- ifu_instr and ifu_pc reflect the head entry and read 0 whenever ifu_valid=0.
- Redirect (any state except IDLE) has priority over push and pop:
  - FIFO is flushed, so ifu_valid=0 next cycle, and the entry presented in the redirect cycle is NOT consumed even if id_ready=1.
  - pc<=redirect_addr.
  - If redirect_addr<PROG_LEN, state -> RUN (also leaves DRAIN/HALT) and halted drops the next cycle.
  - Otherwise state -> DRAIN, then HALT one edge later.
- Redirect in IDLE is ignored.
- fetch_en deasserted in RUN stops pushes only; pops continue and the state is held.
- pc never wraps: no push ever occurs with pc>=PROG_LEN.
- rst_n asserted mid-operation clears everything immediately; in-flight entries are lost.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits), reset 0.
  - Increments (saturating at 0xFFFF) on each edge in RUN with fetch_en=1, no redirect, and no push because the FIFO is full with no pop.
  - Cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Memory holds 0x49, 0xC1, 0x18, 0xA9, 0x4D at addresses 0-4; PROG_LEN=5; id_ready=1; fetch_en=1 from cycle 0.
  - Required: ifu_valid rises at edge 2.
  - Required: (ifu_pc, ifu_instr) sequence (0,0x49), (1,0xC1), (2,0x18), (3,0xA9), (4,0x4D) on consecutive cycles.
  - Required: halted=1 one edge after the last pop and stays 1.
- Back-pressure: same program, id_ready=0 for 6 cycles then 1.
  - Required: count saturates at FIFO_DEPTH=2 with imem_addr held at 2.
  - Required: no entries lost or duplicated; full 5-entry order preserved.
- Redirect: assert redirect_valid with redirect_addr=3 while the head is pc=1.
  - Required: next cycle ifu_valid=0.
  - Required: then (3,0xA9), (4,0x4D), then halted=1; pc=1 is never accepted.
- Out-of-range redirect: redirect_addr=7 in RUN.
  - Required: FIFO flushed, no push, halted=1 two edges later.
  - Required: a subsequent redirect_addr=0 restarts the fetch at (0,0x49).
- Async reset mid-stream: assert rst_n=0 between edges while the FIFO holds 2 entries.
  - Required: ifu_valid=0, imem_addr=0, halted=0 immediately, state IDLE after release.
- With IFU_PERF_CNT_EN defined, hold id_ready=0 for 10 cycles after the FIFO fills.
  - Required: stall_cnt=10.
  - Required: redirect clears stall_cnt to 0.
